digitron_scan_display: RTL and testbench
========================================

// Module: digitron_scan_display
// PURPOSE
//   Parametrised multiplexed 7-segment driver. Takes an unsigned binary value on a Load strobe and
//   converts it to BCD with a sequential double-dabble engine. It then time-multiplexes DIGITS
//   common-cathode digits, with optional leading-zero blanking, per-digit decimal points and an
//   overflow indication. Sits between UART/datapath result registers and the board's digit pins.
// PARAMETERS
//   DIGITS     4      number of digits scanned (1..8); digit 0 = units
//   DATA_W     14     width of Data_In; must satisfy 2^DATA_W <= 10^(DIGITS+2)
//   SCAN_TICKS 50000  CLK cycles per digit slot (1 ms at 50 MHz); >= 2
//   LZ_BLANK   1      1 = blank leading zeros, 0 = show all digits
// PORTS
//   CLK            in   1        system clock, all logic on rising edge
//   RST            in   1        synchronous, active-high reset
//   Data_In        in   DATA_W   unsigned value to display
//   Load           in   1        one-cycle request; sampled only when Busy=0
//   DP_Mask        in   DIGITS   bit i=1 lights decimal point (seg bit 7) of digit i; live, not latched
//   Busy           out  1        conversion in progress
//   Digitron_Out   out  8        segments {dp,g,f,e,d,c,b,a}, active-high
//   DigitronCS_Out out  DIGITS   digit selects, active-low, one-cold
// BEHAVIOUR
//   Reset (RST=1 at an edge): Busy=0; Digitron_Out=8'h00; DigitronCS_Out=all ones. Display register
//     cleared to value 0 (no overflow); prescaler=0; digit index=0; converter IDLE. Aborts any
//     conversion in progress; a pending Load is lost.
//   Converter FSM:
//     - IDLE: if Load=1 at edge t, capture Data_In, clear the BCD register (DIGITS+2 digits), go to
//       SHIFT. Busy=1 from t+1.
//     - SHIFT: DATA_W cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift the
//       {BCD,binary} register left by 1.
//     - COMMIT: one cycle. Low DIGITS nibbles are copied to the display register. The overflow flag
//       is set iff either guard nibble is nonzero. Return to IDLE.
//     - Busy falls at edge t+DATA_W+2; the new value is visible on outputs from the next scan slot
//       boundary onward.
//     - Load while Busy=1 is ignored; no queueing. Load in the cycle Busy has just fallen is accepted.
//     - Display register holds the old value throughout a conversion; never shows partial results.
//   Scan:
//     - The prescaler counts 0..SCAN_TICKS-1 and wraps. At wrap the digit index advances by 1 and
//       DIGITS-1 wraps to 0.
//     - Scanning is independent of the converter and of Load.
//   Outputs are registered and reflect the current index and display register with 1-cycle latency:
//     - DigitronCS_Out = ~(1<<index).
//     - Segment code: 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
//     - Overflow: every digit shows 8'h40 (dash); blanking does not apply.
//     - LZ_BLANK=1: digit i>0 shows 8'h00 when it and all higher digits are 0. Units are never
//       blanked, so value 0 shows "0".
//     - Bit 7 = DP_Mask[index] in all cases, including blanked and overflow digits.
// TESTING
//   (bench: DIGITS=4, DATA_W=14, SCAN_TICKS=4, LZ_BLANK=1)
//   1. RST, Load 1234 -> Busy high exactly 15 cycles; then CS/seg cycle
//      1110/66, 1101/4F, 1011/5B, 0111/06, wrap to 1110, each held 4 cycles.
//   2. Load 7 -> units 07, digits 1..3 00. Load 0 -> units 3F, others 00. Load 1000 -> 3F,3F,3F,06.
//   3. Load 16383 -> all four digits 40 (overflow). Then Load 9999 -> 6F on all digits, overflow cleared.
//   4. Load 1234, then Load 5678 while Busy=1 -> 5678 ignored, display 1234. Load 5678 in the
//      cycle Busy has just fallen -> accepted.
//   5. Load 4321; assert RST 5 cycles into SHIFT -> Busy=0, CS=1111, seg=00 next cycle; after
//      release, display shows 0.
//   6. DP_Mask=0100 with value 5 -> digit 2 shows 80, units 6D; toggle DP_Mask mid-slot ->
//      bit 7 follows with 1-cycle latency.

Source files
------------

// File: rtl/digitron_scan_display.sv
// Multiplexed 7-segment driver: sequential double-dabble binary->BCD converter
// feeding a time-multiplexed common-cathode scan with leading-zero blanking.

module digitron_digit_dec #(
   parameter int DIGITS   = 4,
   parameter int POS      = 0,
   parameter int LZ_BLANK = 1
) (
   input  logic [DIGITS*4-1:0] value,
   input  logic                ovf,
   output logic [6:0]          seg
);
   logic [3:0] nib;
   logic       lead0;
   logic [6:0] code;

   assign nib = value[4*POS +: 4];

   // A digit is a leading zero when it and every more significant digit are zero.
   if (LZ_BLANK != 0 && POS > 0) begin : g_lz
      assign lead0 = (value[DIGITS*4-1:4*POS] == '0);
   end else begin : g_nolz
      assign lead0 = 1'b0;
   end

   always_comb begin
      code = 7'h00;
      case (nib)
         4'd0: code = 7'h3F;
         4'd1: code = 7'h06;
         4'd2: code = 7'h5B;
         4'd3: code = 7'h4F;
         4'd4: code = 7'h66;
         4'd5: code = 7'h6D;
         4'd6: code = 7'h7D;
         4'd7: code = 7'h07;
         4'd8: code = 7'h7F;
         4'd9: code = 7'h6F;
         default: code = 7'h00;
      endcase
   end

   assign seg = ovf ? 7'h40 : (lead0 ? 7'h00 : code);
endmodule

module digitron_scan_display #(
   parameter int DIGITS     = 4,
   parameter int DATA_W     = 14,
   parameter int SCAN_TICKS = 50000,
   parameter int LZ_BLANK   = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] Data_In,
   input  logic              Load,
   input  logic [DIGITS-1:0] DP_Mask,
   output logic              Busy,
   output logic [7:0]        Digitron_Out,
   output logic [DIGITS-1:0] DigitronCS_Out
);
   localparam int BCD_W = (DIGITS + 2) * 4;
   localparam int DSP_W = DIGITS * 4;
   localparam int PW    = $clog2(SCAN_TICKS);
   localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW    = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

   state_t            state, state_nx;
   logic [BCD_W-1:0]  bcd, bcd_nx, bcd_adj;
   logic [DATA_W-1:0] bin, bin_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic              commit;
   logic [DSP_W-1:0]  disp, shown;
   logic              ovf, shown_ovf;
   logic [PW-1:0]     presc;
   logic [IW-1:0]     idx;
   logic              wrap;
   logic [DIGITS-1:0][6:0] seg_d;

   for (genvar k = 0; k < DIGITS + 2; k++) begin : g_adj
      assign bcd_adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
   end

   always_comb begin
      state_nx = state;
      bcd_nx   = bcd;
      bin_nx   = bin;
      cnt_nx   = cnt;
      commit   = 1'b0;
      case (state)
         S_IDLE: if (Load) begin
            bin_nx   = Data_In;
            bcd_nx   = '0;
            cnt_nx   = '0;
            state_nx = S_SHIFT;
         end
         S_SHIFT: begin
            {bcd_nx, bin_nx} = {bcd_adj, bin} << 1;
            cnt_nx = cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) state_nx = S_COMMIT;
         end
         S_COMMIT: begin
            commit   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign Busy = (state != S_IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= S_IDLE;
         bcd   <= '0;
         bin   <= '0;
         cnt   <= '0;
         disp  <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nx;
         bcd   <= bcd_nx;
         bin   <= bin_nx;
         cnt   <= cnt_nx;
         if (commit) begin
            disp <= bcd[DSP_W-1:0];
            ovf  <= |bcd[BCD_W-1:DSP_W];
         end
      end
   end

   // The scanned copy only changes at slot boundaries so a digit never
   // switches value partway through its slot.
   assign wrap = (presc == PW'(SCAN_TICKS - 1));

   always_ff @(posedge CLK) begin
      if (RST) begin
         presc     <= '0;
         idx       <= '0;
         shown     <= '0;
         shown_ovf <= 1'b0;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) begin
            idx       <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            shown     <= disp;
            shown_ovf <= ovf;
         end
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      digitron_digit_dec #(.DIGITS(DIGITS), .POS(i), .LZ_BLANK(LZ_BLANK)) u_dec (
         .value (shown),
         .ovf   (shown_ovf),
         .seg   (seg_d[i])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         Digitron_Out   <= 8'h00;
         DigitronCS_Out <= '1;
      end else begin
         Digitron_Out   <= {DP_Mask[idx], seg_d[idx]};
         DigitronCS_Out <= ~(DIGITS'(1) << idx);
      end
   end
endmodule

// File: tb/tb_digitron_scan_display.sv
// Scoreboard bench: a cycle model built from decimal arithmetic predicts
// Busy/segments/selects each edge; a monitor compares on the falling edge.

module tb_digitron_scan_display;
   localparam int D  = 4;
   localparam int W  = 14;
   localparam int ST = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic [W-1:0] Data_In = '0;
   logic         Load = 1'b0;
   logic [D-1:0] DP_Mask = '0;
   logic         Busy;
   logic [7:0]   Digitron_Out;
   logic [D-1:0] DigitronCS_Out;

   digitron_scan_display #(.DIGITS(D), .DATA_W(W), .SCAN_TICKS(ST), .LZ_BLANK(1)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .Data_In        (Data_In),
      .Load           (Load),
      .DP_Mask        (DP_Mask),
      .Busy           (Busy),
      .Digitron_Out   (Digitron_Out),
      .DigitronCS_Out (DigitronCS_Out)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic         busy;
      logic [7:0]   seg;
      logic [D-1:0] cs;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc_no = 0;

   logic [7:0] segs [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   function automatic int pow10(input int e);
      int r = 1;
      for (int k = 0; k < e; k++) r = r * 10;
      return r;
   endfunction

   // Expected segment byte of digit i when the display holds decimal value v.
   function automatic logic [7:0] exp_seg(input int v, input int i, input logic dp);
      logic [7:0] s;
      if (v >= pow10(D))                 s = 8'h40;
      else if (i > 0 && v < pow10(i))    s = 8'h00;
      else                               s = segs[(v / pow10(i)) % 10];
      s[7] = dp;
      return s;
   endfunction

   // Reference model state
   int   n = 0, disp_v = 0, shown_v = 0, left_c = 0, conv_v = 0;
   logic m_busy = 1'b0;

   always @(posedge CLK) begin
      exp_t e;
      int   ix;
      cyc_no++;
      if (RST) begin
         n = 0; disp_v = 0; shown_v = 0; left_c = 0; m_busy = 1'b0;
         e.busy = 1'b0; e.seg = 8'h00; e.cs = '1;
      end else begin
         ix     = (n / ST) % D;
         e.seg  = exp_seg(shown_v, ix, DP_Mask[ix]);
         e.cs   = ~(D'(1) << ix);
         if (n % ST == ST - 1) shown_v = disp_v;
         n++;
         if (m_busy) begin
            left_c--;
            if (left_c == 0) begin
               disp_v = conv_v;
               m_busy = 1'b0;
            end
         end else if (Load) begin
            conv_v = int'(Data_In);
            left_c = W + 1;
            m_busy = 1'b1;
         end
         e.busy = m_busy;
      end
      q.push_back(e);
   end

   always @(negedge CLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         tests++;
         if ({Busy, Digitron_Out, DigitronCS_Out} !== {e.busy, e.seg, e.cs}) begin
            fails++;
            $display("FAIL outputs cycle %0d: got busy=%b seg=%h cs=%b, want busy=%b seg=%h cs=%b",
                     cyc_no, Busy, Digitron_Out, DigitronCS_Out, e.busy, e.seg, e.cs);
         end
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge CLK);
   endtask

   task automatic load(input int v);
      Data_In = W'(v);
      Load    = 1'b1;
      @(negedge CLK);
      Load    = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (Busy === 1'b1 && k < 100) begin
         @(negedge CLK);
         k++;
      end
      if (k >= 100) begin
         fails++;
         $display("FAIL busy_timeout: Busy still %b after %0d cycles, want 0", Busy, k);
      end
   endtask

   task automatic show(input int v, input int settle);
      load(v);
      wait_idle();
      cyc(settle);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      cyc(3);
      RST = 1'b0;

      show(1234, 2 * D * ST + 2);
      show(7, 2 * D * ST);
      show(0, 2 * D * ST);
      show(1000, 2 * D * ST);
      show(16383, 2 * D * ST);
      show(9999, 2 * D * ST);

      // Load during conversion is dropped; Load on the first idle cycle is taken.
      load(1234);
      cyc(3);
      load(5678);
      wait_idle();
      load(5678);
      wait_idle();
      cyc(2 * D * ST);

      // Reset in the middle of SHIFT.
      load(4321);
      cyc(5);
      RST = 1'b1;
      cyc(1);
      RST = 1'b0;
      cyc(2 * D * ST);

      DP_Mask = 4'b0100;
      show(5, 2 * D * ST);
      for (int k = 0; k < 40; k++) begin
         if (k % 3 == 1) DP_Mask = D'($urandom);
         cyc(1);
      end

      for (int k = 0; k < 120; k++) begin
         r = int'($urandom_range(0, 3));
         case (r)
            0: Data_In = W'($urandom_range(0, 9));
            1: Data_In = W'($urandom_range(10, 999));
            2: Data_In = W'($urandom_range(1000, 9999));
            default: Data_In = W'($urandom_range(0, (1 << W) - 1));
         endcase
         if ($urandom_range(0, 3) == 0) DP_Mask = D'($urandom);
         Load = ($urandom_range(0, 4) != 0);
         RST  = ($urandom_range(0, 39) == 0);
         cyc(1);
         Load = 1'b0;
         RST  = 1'b0;
         cyc(int'($urandom_range(0, 30)));
      end

      cyc(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
